vsa_mc_core: RTL

//  Parametrised successor of the 12-bit Very Simple Architecture core: a non-pipelined,

---
 rtl/vsa_mc_core_if.sv | 29 ++
 rtl/vsa_mc_core.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/vsa_mc_core_if.sv
// Instruction-fetch and data-memory bus of the vsa_mc_core processor.
// The master modport is the core side. The slave modport is the memory or environment side.
// Fetch uses imem_valid; data accesses hold mem_req until mem_ready.
interface vsa_mc_core_if #(
  parameter int DW  = 5,
  parameter int PCW = 5,
  parameter int IW  = 12
);
  logic [PCW-1:0] pc;
  logic           imem_valid;
  logic [IW-1:0]  instr;
  logic [DW-1:0]  mem_addr;
  logic           mem_req;
  logic           mem_wr;
  logic           mem_ready;
  logic [DW-1:0]  datain;
  logic [DW-1:0]  dataout;
  logic [2:0]     state;

  modport master (
    output pc, mem_addr, mem_req, mem_wr, dataout, state,
    input  imem_valid, instr, mem_ready, datain
  );

  modport slave (
    input  pc, mem_addr, mem_req, mem_wr, dataout, state,
    output imem_valid, instr, mem_ready, datain
  );
endinterface

// File: rtl/vsa_mc_core.sv
// Non-pipelined five-state (IF/ID/EX/MEM/WB) VSA core with generic data, PC and register-file sizes.
// Latency: 5 cycles per instruction, plus fetch stalls while imem_valid is low, plus data stalls while mem_ready is low.
// Backpressure: IF holds until imem_valid. MEM holds mem_req until mem_ready. Optional macro VSA_JAL_EN makes opcode 6 a JAL.
// Opcodes: 0=LW 1=SW 2=BEQZ 3=ALU(funct) 4=ADDI 5=SUBI 6=JAL or no-op 7=no-op.
module vsa_mc_core #(
  parameter int DW   = 5,
  parameter int PCW  = 5,
  parameter int NREG = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  vsa_mc_core_if.master  bus
);
  localparam int RAW  = $clog2(NREG);
  localparam int IW   = 6 + 3 * RAW;
  localparam int IMMW = RAW + 3;

  localparam logic [2:0] OP_LW   = 3'd0;
  localparam logic [2:0] OP_SW   = 3'd1;
  localparam logic [2:0] OP_BEQZ = 3'd2;
  localparam logic [2:0] OP_ALU  = 3'd3;
  localparam logic [2:0] OP_ADDI = 3'd4;
  localparam logic [2:0] OP_SUBI = 3'd5;
`ifdef VSA_JAL_EN
  localparam logic [2:0] OP_JAL  = 3'd6;
`endif

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t         st;
  logic [PCW-1:0] pc_q;
  logic [PCW-1:0] npc;
  logic [IW-1:0]  ir;
  logic [DW-1:0]  a;
  logic [DW-1:0]  b;
  logic [DW-1:0]  alu_out;
  logic [DW-1:0]  lmd;
  logic           cond;
  logic           mem_req_q;
  logic           mem_wr_q;
  logic [DW-1:0]  rf [NREG];

  // Instruction fields decoded from IR.
  logic [2:0]      opcode;
  logic [RAW-1:0]  rs1;
  logic [RAW-1:0]  rs2;
  logic [RAW-1:0]  rd;
  logic [2:0]      funct;
  logic [IMMW-1:0] imm;
  logic [DW-1:0]   sx;
  logic [PCW-1:0]  br_off;
  logic [PCW-1:0]  br_tgt;
  logic            is_mem;

  assign opcode = ir[IW-1 -: 3];
  assign rs1    = ir[IW-4 -: RAW];
  assign rs2    = ir[IW-4-RAW -: RAW];
  assign rd     = ir[IMMW-1 -: RAW];
  assign funct  = ir[2:0];
  assign imm    = ir[IMMW-1:0];
  assign sx     = DW'($signed(imm));
  assign br_off = PCW'($signed(imm)) << 1;
  assign br_tgt = npc + br_off;
  assign is_mem = (opcode == OP_LW) || (opcode == OP_SW);

  logic [DW-1:0]  ex_res;
  logic [PCW-1:0] next_pc;
  logic           wb_en;
  logic [RAW-1:0] wb_idx;
  logic [DW-1:0]  wb_val;

  // EX-stage result for the current opcode. Unused opcodes produce zero.
  always_comb begin
    ex_res = '0;
    case (opcode)
      OP_LW, OP_SW, OP_ADDI: ex_res = a + sx;
      OP_SUBI:               ex_res = a - sx;
      OP_BEQZ:               ex_res = DW'(br_tgt);
      OP_ALU: begin
        case (funct)
          3'd0: ex_res = a + b;
          3'd1: ex_res = a - b;
          3'd2: ex_res = a & b;
          3'd3: ex_res = a | b;
          3'd4: ex_res = a ^ b;
          3'd5: ex_res = ~a;
          3'd6: ex_res = a >> 1;
          3'd7: ex_res = {a[DW-1], a[DW-1:1]};
          default: ex_res = '0;
        endcase
      end
`ifdef VSA_JAL_EN
      OP_JAL:                ex_res = DW'(br_tgt);
`endif
      default:               ex_res = '0;
    endcase
  end

  // PC committed at the end of MEM: a taken branch (or JAL) goes to ALUOutput, otherwise to NPC.
  always_comb begin
    next_pc = npc;
    if (opcode == OP_BEQZ && cond) next_pc = PCW'(alu_out);
`ifdef VSA_JAL_EN
    if (opcode == OP_JAL) next_pc = PCW'(alu_out);
`endif
  end

  // Write-back target and value. Writes to R0 are dropped so R0 stays zero.
  always_comb begin
    wb_en  = 1'b0;
    wb_idx = rs2;
    wb_val = alu_out;
    case (opcode)
      OP_ALU: begin
        wb_en  = 1'b1;
        wb_idx = rd;
      end
      OP_ADDI, OP_SUBI: wb_en = 1'b1;
      OP_LW: begin
        wb_en  = 1'b1;
        wb_val = lmd;
      end
`ifdef VSA_JAL_EN
      OP_JAL: begin
        wb_en  = 1'b1;
        wb_val = DW'(npc);
      end
`endif
      default: wb_en = 1'b0;
    endcase
    if (wb_idx == '0) wb_en = 1'b0;
  end

  // Main state machine. Synchronous reset clears every architectural and pipeline register and aborts any open access.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      st        <= S_IF;
      pc_q      <= '0;
      npc       <= '0;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      alu_out   <= '0;
      lmd       <= '0;
      cond      <= 1'b0;
      mem_req_q <= 1'b0;
      mem_wr_q  <= 1'b0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      case (st)
        S_IF: begin
          if (bus.imem_valid) begin
            ir  <= bus.instr;
            npc <= pc_q + PCW'(2);
            st  <= S_ID;
          end
        end
        S_ID: begin
          a  <= rf[rs1];
          b  <= rf[rs2];
          st <= S_EX;
        end
        S_EX: begin
          alu_out <= ex_res;
          if (opcode == OP_BEQZ) cond <= (a == '0);
          if (is_mem) begin
            mem_req_q <= 1'b1;
            mem_wr_q  <= (opcode == OP_SW);
          end
          st <= S_MEM;
        end
        S_MEM: begin
          if (!is_mem || bus.mem_ready) begin
            if (opcode == OP_LW) lmd <= bus.datain;
            mem_req_q <= 1'b0;
            mem_wr_q  <= 1'b0;
            pc_q      <= next_pc;
            st        <= S_WB;
          end
        end
        S_WB: begin
          if (wb_en) rf[wb_idx] <= wb_val;
          st <= S_IF;
        end
        default: st <= S_IF;
      endcase
    end
  end

  assign bus.pc       = pc_q;
  assign bus.mem_addr = alu_out;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_wr   = mem_wr_q;
  assign bus.dataout  = b;
  assign bus.state    = st;
endmodule
